serial_frame_tx: RTL
====================

# serial_frame_tx

Serial frame transmitter that drives the single-bit stream consumed by the team's 1101 sequence detector. It accepts a 16-bit parallel word through a ready/load handshake. It then emits a 4-bit sync marker (default 1101), followed by the 16-bit payload MSB first, followed by a guard gap of idle zeros, one bit per clock. It sits between a word producer and the detector, and serves as the bit-stream source for detector test and link bring-up.

## Interface
- DATA_W, 16, payload width in bits (≥1)
- SYNC_W, 4, sync marker width in bits (≥1)
- SYNC, 4'b1101, sync marker, sent MSB first
- GAP_W, 2, idle zero bits after payload (≥0)
- clk  input  1  rising-edge clock; one clock domain, no other clocks
- rst_n  input  1  reset, synchronous, active-low; sampled on rising clk
- data_in  input  DATA_W  payload word; sampled only on an accept cycle
- load  input  1  producer request; accept = load && ready
- ready  output  1  high only in IDLE; block can accept a word
- bit_out  output  1  serial bit; forced 0 whenever bit_valid=0
- bit_valid  output  1  high during sync and payload bits, low in IDLE and GAP
- sync_phase  output  1  high while bit_out carries a sync-marker bit
- done  output  1  one-cycle pulse, coincident with the last payload bit

## Operation
- States: IDLE, SYNC, DATA, GAP. Reset state is IDLE.
- IDLE: ready=1, all other outputs 0.
  - On accept, latch data_in into a DATA_W shift register, latch SYNC into a SYNC_W shift register, and go to SYNC.
- SYNC: bit_out = MSB of the sync register; bit_valid=1; sync_phase=1.
  - Shift left by 1 per cycle.
  - After SYNC_W cycles, go to DATA.
- DATA: bit_out = MSB of the payload register; bit_valid=1.
  - Shift left by 1 per cycle, zero-filling the LSB.
  - After DATA_W cycles, go to GAP; if GAP_W=0, go to IDLE instead.
  - done=1 in the final DATA cycle only.
- GAP: bit_out=0, bit_valid=0, for GAP_W cycles, then go to IDLE.
- Bit counter: width $clog2(max(SYNC_W, DATA_W, GAP_W)+1). It is reloaded on every state entry and counts down to 1. Counter reads are never out of range.
- load while ready=0 is ignored. data_in changes while busy have no effect.
- Payload containing the sync pattern is transmitted unmodified. No bit stuffing; any such detection is the detector's concern.
- Reset has priority over all other behaviour. With rst_n=0 at an edge, in any state:
  - state goes to IDLE;
  - both shift registers and the counter clear;
  - ready=1 and all other outputs=0 from that edge onward.
- An aborted frame is never resumed.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Accept at edge E0 (IDLE, load=1). The first sync bit appears after E0, i.e. in cycle 1; latency is 1 cycle.
- Cycles 1..SYNC_W: sync bits. Cycles SYNC_W+1..SYNC_W+DATA_W: payload bits. done falls in cycle SYNC_W+DATA_W.
- The next GAP_W cycles are gap. IDLE (ready=1) follows immediately after the gap.
- With load held high, the frame period is 1+SYNC_W+DATA_W+GAP_W cycles; with defaults, 23 cycles.
- At least one IDLE cycle always separates frames, so ready is never high while bit_valid=1.
- Reset released (rst_n 0→1): the block is in IDLE, and the first accept is possible in the cycle rst_n is first sampled high.

## Test plan
- Single frame, data_in=16'hA5F0, defaults:
  - bit_out over cycles 1..20 = 1101 1010010111110000;
  - sync_phase high in cycles 1..4; done only in cycle 20;
  - cycles 21..22 bit_out=0, bit_valid=0; ready=1 in cycle 23.
- Back-to-back 16'hFFFF then 16'h0000 with load held high:
  - second sync starts exactly 23 cycles after the first;
  - payloads are all-ones, then all-zeros;
  - bit_out is 0 in both gaps.
- Load ignored while busy: pulse load with data_in=16'h1234 at cycle 8 of a 16'hA5F0 frame.
  - Frame output is unchanged. No second frame is sent until load is asserted in IDLE.
- Reset mid-frame: drive rst_n=0 for one cycle during payload bit 6.
  - Next cycle: ready=1, bit_valid=0, bit_out=0, done=0.
  - A fresh load of 16'h00FF then produces a complete, correct frame.
- Loopback: feed bit_out into the sequence detector with data_in=16'h0000.
  - The detector's output pulses exactly once per frame, on the final sync bit.
- Parameter variant GAP_W=0, SYNC=4'b1011:
  - frame period is 21 cycles;
  - sync bits are 1011;
  - IDLE is the cycle immediately after done.

Source files
------------

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
// Serial frame source for the 1101 sequence detector. It takes a parallel
// word through a ready/load handshake, then sends one bit per clock: a sync
// marker (MSB first), the payload (MSB first), and GAP_W idle zero bits.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   data_in    payload word, sampled only on accept (load && ready)
//   load       producer request
//   ready      high only while idle
//   bit_out    serial bit, 0 whenever bit_valid is low
//   bit_valid  high during sync and payload bits
//   sync_phase high while bit_out carries a sync-marker bit
//   done       one-cycle pulse on the last payload bit
//
// State | meaning
// IDLE  | waiting for load; ready=1
// SYNC  | shifting out the sync marker
// DATA  | shifting out the payload; done on the final bit
// GAP   | idle zero bits before returning to IDLE
module serial_frame_tx #(
  parameter int                DATA_W = 16,
  parameter int                SYNC_W = 4,
  parameter logic [SYNC_W-1:0] SYNC   = 4'b1101,
  parameter int                GAP_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              sync_phase,
  output logic              done
);

  localparam int MAX_SD = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAX_W  = (MAX_SD > GAP_W) ? MAX_SD : GAP_W;
  localparam int CNT_W  = $clog2(MAX_W + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SYNC_W-1:0] sync_q, sync_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic ready_q, ready_d;
  logic bit_out_q, bit_out_d;
  logic bit_valid_q, bit_valid_d;
  logic sync_phase_q, sync_phase_d;
  logic done_q, done_d;

  logic last_bit;

  // The counter is reloaded on each state entry and the move happens when
  // it reaches 1, so every state lasts exactly its reload value in cycles.
  assign last_bit = (cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sync_d  = sync_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_SYNC;
          cnt_d   = CNT_W'(SYNC_W);
          sync_d  = SYNC;
          data_d  = data_in;
        end
      end
      ST_SYNC: begin
        sync_d = sync_q << 1;
        if (last_bit) begin
          state_d = ST_DATA;
          cnt_d   = CNT_W'(DATA_W);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        data_d = data_q << 1;
        if (last_bit) begin
          if (GAP_W == 0) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_GAP;
            cnt_d   = CNT_W'(GAP_W);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (last_bit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that they can be registered
  // alongside it, keeping every output a flop with no input-to-output path.
  always_comb begin
    ready_d      = (state_d == ST_IDLE);
    bit_valid_d  = (state_d == ST_SYNC) || (state_d == ST_DATA);
    sync_phase_d = (state_d == ST_SYNC);
    done_d       = (state_d == ST_DATA) && (cnt_d == CNT_W'(1));
    bit_out_d    = 1'b0;
    if (state_d == ST_SYNC) begin
      bit_out_d = sync_d[SYNC_W-1];
    end else if (state_d == ST_DATA) begin
      bit_out_d = data_d[DATA_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sync_q       <= '0;
      data_q       <= '0;
      ready_q      <= 1'b1;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      sync_phase_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync_q       <= sync_d;
      data_q       <= data_d;
      ready_q      <= ready_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      sync_phase_q <= sync_phase_d;
      done_q       <= done_d;
    end
  end

  assign ready      = ready_q;
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign sync_phase = sync_phase_q;
  assign done       = done_q;

endmodule
